// File: rtl/sccb_init_pkg.sv
// Shared types and constants for the SCCB register-init sequencer.
package sccb_init_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StPwrup,
    StFetch,
    StRomWait,
    StDecode,
    StWrite,
    StGap,
    StDelay,
    StNext,
    StDone,
    StError
  } state_e;

  // Reserved register addresses that act as table commands.
  localparam logic [15:0] DelayMark = 16'hFFFF;
  localparam logic [15:0] EndMark   = 16'hFFFE;
  localparam logic [15:0] NopMark   = 16'h0000;

  // Width of the millisecond down-counter (delays up to 255 ms).
  localparam int unsigned MsCntW = 8;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sccb_init_if.sv
// Write-request handshake between the init sequencer and the SCCB master.
interface sccb_init_if #(
  parameter int unsigned REG_ADDR_W = 16,
  parameter int unsigned REG_DATA_W = 8
);
  logic                  req;
  logic [REG_ADDR_W-1:0] reg_addr;
  logic [REG_DATA_W-1:0] reg_data;
  logic                  done;
  logic                  nack;

  // Requesting side (the sequencer).
  modport master (
    output req,
    output reg_addr,
    output reg_data,
    input  done,
    input  nack
  );

  // Serving side (the SCCB bus master).
  modport slave (
    input  req,
    input  reg_addr,
    input  reg_data,
    output done,
    output nack
  );
endinterface

// File: rtl/sccb_init_sequencer_timer.sv
// Millisecond delay timer: a cycle prescaler feeding an ms down-counter.
// expired_o is high during the final cycle of the loaded interval, so a
// state waiting on it occupies exactly N*TICK_CYCLES cycles after load.
module ms_tick_timer
  import sccb_init_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 50000,
  parameter int unsigned CNT_W       = MsCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] n_i,
  output logic             expired_o
);

  localparam int unsigned PrescW = (clog2(TICK_CYCLES) > 0) ? clog2(TICK_CYCLES) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_CYCLES - 1);

  logic [PrescW-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]  ms_q, ms_d;

  // Next-state: load restarts from zero; otherwise count down while ms remain.
  always_comb begin
    presc_d = presc_q;
    ms_d    = ms_q;
    if (load_i) begin
      presc_d = '0;
      ms_d    = n_i;
    end else if (ms_q != '0) begin
      if (presc_q == PrescLast) begin
        presc_d = '0;
        ms_d    = ms_q - CNT_W'(1);
      end else begin
        presc_d = presc_q + PrescW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else begin
      presc_q <= presc_d;
      ms_q    <= ms_d;
    end
  end

  assign expired_o = (ms_q == '0) || ((ms_q == CNT_W'(1)) && (presc_q == PrescLast));

endmodule

// File: rtl/sccb_init_sequencer.sv
// Camera register-init engine: walks one init table in an external
// synchronous ROM and turns entries into SCCB writes, delays or skips.
module sccb_init_sequencer
  import sccb_init_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 16,
  parameter int unsigned REG_DATA_W  = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned NUM_TABLES  = 2,
  parameter int unsigned TICK_CYCLES = 50000,
  parameter int unsigned POWERUP_MS  = 20,
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [REG_ADDR_W-1:0] DELAY_MARK = REG_ADDR_W'(DelayMark),
  parameter logic [REG_ADDR_W-1:0] END_MARK   = REG_ADDR_W'(EndMark),
  parameter logic [REG_ADDR_W-1:0] NOP_MARK   = REG_ADDR_W'(NopMark),
  localparam int unsigned ENTRY_W    = REG_ADDR_W + REG_DATA_W,
  localparam int unsigned IDX_W      = clog2(DEPTH),
  localparam int unsigned SEL_W      = (clog2(NUM_TABLES) > 1) ? clog2(NUM_TABLES) : 1,
  localparam int unsigned ROM_ADDR_W = clog2(DEPTH * NUM_TABLES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [SEL_W-1:0]      table_sel_i,
  output logic [ROM_ADDR_W-1:0] rom_addr_o,
  input  logic [ENTRY_W-1:0]    rom_q_i,
  sccb_init_if.master           sccb,
  output logic                  busy_o,
  output logic                  init_done_o,
  output logic                  init_err_o,
  output logic [IDX_W-1:0]      err_index_o
);

  localparam int unsigned RetryW = (clog2(MAX_RETRY + 1) > 0) ? clog2(MAX_RETRY + 1) : 1;
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ENTRY_W-1:0]  entry_q, entry_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [IDX_W-1:0]    err_idx_q, err_idx_d;
  logic [RetryW-1:0]   retry_inc;
  logic                tmr_load;
  logic [MsCntW-1:0]   tmr_n;
  logic                tmr_expired;
  logic [REG_ADDR_W-1:0] rom_reg_addr;
  logic [REG_DATA_W-1:0] rom_reg_data;

  assign rom_reg_addr = rom_q_i[ENTRY_W-1:REG_DATA_W];
  assign rom_reg_data = rom_q_i[REG_DATA_W-1:0];
  assign retry_inc    = retry_q + RetryW'(1);

  ms_tick_timer #(
    .TICK_CYCLES (TICK_CYCLES),
    .CNT_W       (MsCntW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .n_i       (tmr_n),
    .expired_o (tmr_expired)
  );

  // Next-state logic: start acceptance, entry dispatch, write/retry handling.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    entry_d   = entry_q;
    retry_d   = retry_q;
    err_idx_d = err_idx_q;
    tmr_load  = 1'b0;
    tmr_n     = '0;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          idx_d   = '0;
          retry_d = '0;
          // Out-of-range selections fall back to the last table.
          if (32'(table_sel_i) >= NUM_TABLES) begin
            sel_d = SEL_W'(NUM_TABLES - 1);
          end else begin
            sel_d = table_sel_i;
          end
          if (POWERUP_MS == 0) begin
            state_d = StFetch;
          end else begin
            tmr_load = 1'b1;
            tmr_n    = MsCntW'(POWERUP_MS);
            state_d  = StPwrup;
          end
        end
      end
      StPwrup: begin
        if (tmr_expired) state_d = StFetch;
      end
      StFetch:   state_d = StRomWait;
      StRomWait: state_d = StDecode;
      StDecode: begin
        entry_d = rom_q_i;
        retry_d = '0;
        if (rom_reg_addr == END_MARK) begin
          state_d = StDone;
        end else if (rom_reg_addr == NOP_MARK) begin
          state_d = StNext;
        end else if (rom_reg_addr == DELAY_MARK) begin
          tmr_load = 1'b1;
          tmr_n    = MsCntW'(rom_reg_data);
          state_d  = StDelay;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (sccb.done) begin
          if (!sccb.nack) begin
            retry_d = '0;
            state_d = StNext;
          end else begin
            retry_d = retry_inc;
            if (retry_inc < RetryW'(MAX_RETRY)) begin
              state_d = StGap;
            end else begin
              err_idx_d = idx_q;
              state_d   = StError;
            end
          end
        end
      end
      // One idle cycle with req low so the master sees a fresh request.
      StGap:   state_d = StWrite;
      StDelay: begin
        if (tmr_expired) state_d = StNext;
      end
      StNext: begin
        if (idx_q == IdxLast) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      sel_q     <= '0;
      entry_q   <= '0;
      retry_q   <= '0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      entry_q   <= entry_d;
      retry_q   <= retry_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Outputs decode straight from state so req falls with an async reset.
  always_comb begin
    rom_addr_o    = ROM_ADDR_W'(sel_q) * ROM_ADDR_W'(DEPTH) + ROM_ADDR_W'(idx_q);
    sccb.req      = (state_q == StWrite);
    sccb.reg_addr = entry_q[ENTRY_W-1:REG_DATA_W];
    sccb.reg_data = entry_q[REG_DATA_W-1:0];
    busy_o        = !((state_q == StIdle) || (state_q == StDone) || (state_q == StError));
    init_done_o   = (state_q == StDone);
    init_err_o    = (state_q == StError);
    err_index_o   = err_idx_q;
  end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Scoreboard bench: expected writes are queued by the stimulus, and a
// negedge monitor pops and checks them on every rising sccb req.
module tb_sccb_init_sequencer;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned EW = 24;
  localparam int unsigned ARAW = 9;   // 256 entries x 2 tables
  localparam int unsigned BRAW = 4;   // 4 entries x 3 tables

  typedef struct packed {
    logic [11:0] ra;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- DUT A: 256-deep, 2 tables, 2 ms power-up ----------------
  logic            a_start, a_sel;
  logic [ARAW-1:0] a_rom_addr;
  logic [EW-1:0]   a_rom_q;
  logic            a_busy, a_done, a_err;
  logic [7:0]      a_err_idx;
  logic [EW-1:0]   a_rom [0:(1<<ARAW)-1];

  sccb_init_if #(.REG_ADDR_W(AW), .REG_DATA_W(DW)) a_bus ();

  sccb_init_sequencer #(
    .DEPTH(256), .NUM_TABLES(2), .TICK_CYCLES(10), .POWERUP_MS(2), .MAX_RETRY(3)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(a_start), .table_sel_i(a_sel),
    .rom_addr_o(a_rom_addr), .rom_q_i(a_rom_q), .sccb(a_bus),
    .busy_o(a_busy), .init_done_o(a_done), .init_err_o(a_err), .err_index_o(a_err_idx)
  );

  always @(posedge clk) a_rom_q <= a_rom[a_rom_addr];

  // ---------------- DUT B: 4-deep, 3 tables, no power-up wait ----------------
  logic            b_start;
  logic [1:0]      b_sel;
  logic [BRAW-1:0] b_rom_addr;
  logic [EW-1:0]   b_rom_q;
  logic            b_busy, b_done, b_err;
  logic [1:0]      b_err_idx;
  logic [EW-1:0]   b_rom [0:(1<<BRAW)-1];

  sccb_init_if #(.REG_ADDR_W(AW), .REG_DATA_W(DW)) b_bus ();

  sccb_init_sequencer #(
    .DEPTH(4), .NUM_TABLES(3), .TICK_CYCLES(10), .POWERUP_MS(0), .MAX_RETRY(3)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .table_sel_i(b_sel),
    .rom_addr_o(b_rom_addr), .rom_q_i(b_rom_q), .sccb(b_bus),
    .busy_o(b_busy), .init_done_o(b_done), .init_err_o(b_err), .err_index_o(b_err_idx)
  );

  always @(posedge clk) b_rom_q <= b_rom[b_rom_addr];

  // ---------------- scoreboards ----------------
  exp_t a_exp[$];
  exp_t b_exp[$];
  exp_t a_e, b_e;
  int a_rises = 0, b_rises = 0;
  int a_low_run = 0;
  bit a_prev_req = 1'b0, b_prev_req = 1'b0;
  bit a_last_nack = 1'b0;
  int a_lat_exp = -1, b_lat_exp = -1;
  int unsigned a_start_cyc = 0, b_start_cyc = 0;
  int unsigned b_max_addr = 0;

  // Bus responders: ack after a latency, NACK a chosen address on demand.
  int a_ack_lat = 5;
  logic [15:0] a_nack_addr = 16'h0;
  int a_nack_budget = 0;

  initial begin
    a_bus.done = 1'b0;
    a_bus.nack = 1'b0;
    forever begin
      @(negedge clk);
      if (a_bus.req) begin
        for (int w = 1; w < a_ack_lat && a_bus.req; w++) @(negedge clk);
        if (a_bus.req) begin
          a_bus.done = 1'b1;
          if (a_bus.reg_addr == a_nack_addr && a_nack_budget > 0) begin
            a_bus.nack = 1'b1;
            a_nack_budget--;
            a_last_nack = 1'b1;
          end else begin
            a_bus.nack = 1'b0;
            a_last_nack = 1'b0;
          end
          @(negedge clk);
          a_bus.done = 1'b0;
          a_bus.nack = 1'b0;
        end
      end
    end
  end

  initial begin
    b_bus.done = 1'b0;
    b_bus.nack = 1'b0;
    forever begin
      @(negedge clk);
      if (b_bus.req) begin
        for (int w = 1; w < 3 && b_bus.req; w++) @(negedge clk);
        if (b_bus.req) begin
          b_bus.done = 1'b1;
          @(negedge clk);
          b_bus.done = 1'b0;
        end
      end
    end
  end

  // Monitors: compare every new write request against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && a_bus.req && !a_prev_req) begin
      a_rises++;
      if (a_lat_exp >= 0) begin
        check("a_first_req_latency", longint'(cyc - a_start_cyc), a_lat_exp);
        a_lat_exp = -1;
      end
      if (a_last_nack) check("a_retry_gap_cycles", a_low_run, 1);
      check("a_write_expected", a_exp.size() > 0, 1);
      if (a_exp.size() > 0) begin
        a_e = a_exp.pop_front();
        check("a_rom_addr", a_rom_addr, a_e.ra);
        check("a_reg_addr", a_bus.reg_addr, a_e.addr);
        check("a_reg_data", a_bus.reg_data, a_e.data);
      end
    end
    if (a_bus.req) a_low_run = 0;
    else a_low_run++;
    a_prev_req = a_bus.req;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (32'(b_rom_addr) > b_max_addr) b_max_addr = 32'(b_rom_addr);
      if (b_bus.req && !b_prev_req) begin
        b_rises++;
        if (b_lat_exp >= 0) begin
          check("b_first_req_latency", longint'(cyc - b_start_cyc), b_lat_exp);
          b_lat_exp = -1;
        end
        check("b_write_expected", b_exp.size() > 0, 1);
        if (b_exp.size() > 0) begin
          b_e = b_exp.pop_front();
          check("b_rom_addr", b_rom_addr, b_e.ra);
          check("b_reg_addr", b_bus.reg_addr, b_e.addr);
          check("b_reg_data", b_bus.reg_data, b_e.data);
        end
      end
    end
    b_prev_req = b_bus.req;
  end

  // ---------------- helpers ----------------
  task automatic a_push(input int ra, input logic [15:0] addr, input logic [7:0] data);
    exp_t e;
    e.ra = 12'(ra);
    e.addr = addr;
    e.data = data;
    a_exp.push_back(e);
  endtask

  task automatic start_a(input logic sel, input int lat);
    @(negedge clk);
    a_start = 1'b1;
    a_sel = sel;
    @(negedge clk);
    a_start = 1'b0;
    a_start_cyc = cyc;
    a_lat_exp = lat;
    a_last_nack = 1'b0;
  endtask

  task automatic wait_idle_a(input int limit);
    for (int n = 0; n < limit && a_busy; n++) @(negedge clk);
    check("a_finished_in_time", a_busy, 0);
  endtask

  task automatic wait_req_a(input int limit);
    for (int n = 0; n < limit && !a_bus.req; n++) @(negedge clk);
    check("a_req_seen", a_bus.req, 1);
  endtask

  task automatic end_test_a(input int writes);
    check("a_write_count", a_rises, writes);
    check("a_scoreboard_drained", a_exp.size(), 0);
    a_rises = 0;
  endtask

  // Watchdog: a hang is reported, never silent.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    a_start = 1'b0; a_sel = 1'b0;
    b_start = 1'b0; b_sel = 2'd0;
    for (int i = 0; i < (1 << ARAW); i++) a_rom[i] = '0;
    for (int i = 0; i < (1 << BRAW); i++) b_rom[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_req", a_bus.req, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);
    check("rst_err_index", a_err_idx, 0);
    check("rst_rom_addr", a_rom_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal: table 1, two writes then END; 20 power-up + 3 cycles to req.
    a_rom[256] = 24'h3103_11;
    a_rom[257] = 24'h3008_42;
    a_rom[258] = 24'hFFFE_00;
    a_push(256, 16'h3103, 8'h11);
    a_push(257, 16'h3008, 8'h42);
    start_a(1'b1, 23);
    check("nom_busy_after_start", a_busy, 1);
    wait_idle_a(300);
    check("nom_done", a_done, 1);
    check("nom_err", a_err, 0);
    end_test_a(2);

    // Delay 5 ms, NOP, one write: 20 + 3 + 50 + 1 + 4 + 3 = 81 cycles to req.
    a_rom[0] = 24'hFFFF_05;
    a_rom[1] = 24'h0000_00;
    a_rom[2] = 24'h4300_00;
    a_rom[3] = 24'hFFFE_00;
    a_push(2, 16'h4300, 8'h00);
    start_a(1'b0, 81);
    wait_idle_a(400);
    check("dly_done", a_done, 1);
    end_test_a(1);

    // Retry: two NACKs then ACK on 501f; sequence continues.
    a_rom[256] = 24'h501f_03;
    a_rom[257] = 24'h1111_22;
    a_rom[258] = 24'hFFFE_00;
    a_nack_addr = 16'h501f;
    a_nack_budget = 2;
    for (int k = 0; k < 3; k++) a_push(256, 16'h501f, 8'h03);
    a_push(257, 16'h1111, 8'h22);
    start_a(1'b1, 23);
    wait_idle_a(400);
    check("rty_done", a_done, 1);
    check("rty_err", a_err, 0);
    end_test_a(4);

    // Failure: entry 7 always NACKed -> three attempts then ERROR.
    for (int i = 0; i < 7; i++) a_rom[i] = {16'(16'h2000 + i), 8'(i)};
    a_rom[7] = 24'h7777_77;
    a_rom[8] = 24'hFFFE_00;
    a_nack_addr = 16'h7777;
    a_nack_budget = 100;
    for (int i = 0; i < 7; i++) a_push(i, 16'(16'h2000 + i), 8'(i));
    for (int k = 0; k < 3; k++) a_push(7, 16'h7777, 8'h77);
    start_a(1'b0, 23);
    wait_idle_a(800);
    check("fail_err", a_err, 1);
    check("fail_done", a_done, 0);
    check("fail_err_index", a_err_idx, 7);
    repeat (20) @(negedge clk);
    check("fail_no_further_fetch", a_rom_addr, 7);
    end_test_a(10);

    // Restart after error: flags clear and the table runs from idx 0.
    a_nack_budget = 0;
    for (int i = 0; i < 7; i++) a_push(i, 16'(16'h2000 + i), 8'(i));
    a_push(7, 16'h7777, 8'h77);
    start_a(1'b0, 23);
    check("restart_err_cleared", a_err, 0);
    check("restart_busy", a_busy, 1);
    wait_idle_a(800);
    check("restart_done", a_done, 1);
    end_test_a(8);

    // Full table without END on DUT B; sel 3 clamps to table 2 (addr 8..11).
    b_rom[8]  = 24'h6000_a0;
    b_rom[9]  = 24'h6001_a1;
    b_rom[10] = 24'h6002_a2;
    b_rom[11] = 24'h6003_a3;
    for (int i = 0; i < 4; i++) begin
      b_e.ra = 12'(8 + i);
      b_e.addr = 16'(16'h6000 + i);
      b_e.data = 8'(8'ha0 + i);
      b_exp.push_back(b_e);
    end
    b_max_addr = 0;
    @(negedge clk);
    b_start = 1'b1;
    b_sel = 2'd3;
    @(negedge clk);
    b_start = 1'b0;
    b_start_cyc = cyc;
    b_lat_exp = 3;
    for (int n = 0; n < 200 && b_busy; n++) @(negedge clk);
    check("full_finished_in_time", b_busy, 0);
    check("full_done", b_done, 1);
    check("full_write_count", b_rises, 4);
    check("full_scoreboard_drained", b_exp.size(), 0);
    check("full_rom_addr_max", b_max_addr, 11);

    // Start pulse during WRITE is ignored (table 0 would give other addresses).
    a_ack_lat = 20;
    a_rom[256] = 24'h5555_01;
    a_rom[257] = 24'h5556_02;
    a_rom[258] = 24'hFFFE_00;
    a_push(256, 16'h5555, 8'h01);
    a_push(257, 16'h5556, 8'h02);
    start_a(1'b1, 23);
    wait_req_a(100);
    @(negedge clk);
    a_start = 1'b1;
    a_sel = 1'b0;
    @(negedge clk);
    a_start = 1'b0;
    check("abuse_still_busy", a_busy, 1);
    wait_idle_a(400);
    check("abuse_done", a_done, 1);
    end_test_a(2);

    // Reset during WRITE: req drops before the next clock edge.
    a_push(256, 16'h5555, 8'h01);
    start_a(1'b1, 23);
    wait_req_a(100);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_req_async", a_bus.req, 0);
    check("rstw_busy", a_busy, 0);
    check("rstw_done", a_done, 0);
    check("rstw_rom_addr", a_rom_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rstw_no_activity", a_rises, 1);
    check("rstw_idle_busy", a_busy, 0);
    check("rstw_scoreboard_drained", a_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- Generic camera register-init engine that walks one of NUM_TABLES init tables held in an external synchronous ROM.
- Issues each {reg_addr, reg_data} entry as a write request to the SCCB master.
- Executes in-table delay and end markers, skips NOP entries, and retries NACKed writes.
- Sits between the init-table ROMs (RAW/RGB modes) and the SCCB master; reports done/error to the camera top.

Parameters:
- REG_ADDR_W, 16, register address width.
- REG_DATA_W, 8, register data width; ENTRY_W = REG_ADDR_W + REG_DATA_W (localparam).
- DEPTH, 256, entries per table; IDX_W = clog2(DEPTH).
- NUM_TABLES, 2, number of mode tables; SEL_W = max(1, clog2(NUM_TABLES)); ROM_ADDR_W = clog2(DEPTH*NUM_TABLES).
- TICK_CYCLES, 50000, clk cycles per 1 ms delay unit.
- POWERUP_MS, 20, wait after start before the first fetch.
- MAX_RETRY, 3, write attempts per entry before error.
- DELAY_MARK, 16'hFFFF, entry address meaning "wait data ms".
- END_MARK, 16'hFFFE, entry address meaning "table ends here".
- NOP_MARK, 16'h0000, entry address meaning "skip" (unused ROM slots).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that starts the sequence.
- table_sel  in  SEL_W  table index, latched on an accepted start.
- rom_addr  out  ROM_ADDR_W  = sel*DEPTH + idx.
- rom_q  in  ENTRY_W  ROM data, valid 1 cycle after rom_addr.
- sccb_req  out  1  write request, level-held.
- sccb_reg_addr  out  REG_ADDR_W  register address.
- sccb_reg_data  out  REG_DATA_W  register data.
- sccb_done  in  1  one-cycle pulse from the master when a transfer completes.
- sccb_nack  in  1  valid with sccb_done; 1 = NACK.
- busy  out  1  high from accepted start until DONE or ERROR.
- init_done  out  1  sticky success flag.
- init_err  out  1  sticky failure flag.
- err_index  out  IDX_W  index of the failing entry.

Behaviour:
- Reset values: all outputs 0; state IDLE; idx 0; retry count 0.
- start acceptance:
  - Accepted only in IDLE, DONE or ERROR; ignored while busy.
  - On accept: busy=1, init_done=0, init_err=0, idx=0, latch table_sel.
  - table_sel >= NUM_TABLES is accepted and clamps to NUM_TABLES-1.
- States: IDLE, PWRUP, FETCH, ROMWAIT, DECODE, WRITE, GAP, DELAY, NEXT, DONE, ERROR.
- PWRUP: waits POWERUP_MS*TICK_CYCLES cycles; if POWERUP_MS=0, goes directly to FETCH.
- FETCH: drives rom_addr. ROMWAIT: one cycle. DECODE: registers rom_q and dispatches:
  - addr==END_MARK -> DONE.
  - addr==NOP_MARK -> NEXT.
  - addr==DELAY_MARK -> DELAY with N = data; N=0 -> NEXT the following cycle.
  - otherwise -> WRITE.
- WRITE:
  - sccb_req=1; sccb_reg_addr/data stay stable until sccb_done.
  - sccb_done & !sccb_nack -> req=0, retry count=0, NEXT.
  - sccb_done & sccb_nack -> retry count+1. If count < MAX_RETRY, go to GAP: req=0 for exactly 1 cycle, then back to WRITE with the same entry. Otherwise -> ERROR.
- DELAY: counts N*TICK_CYCLES cycles via the ms tick, then NEXT.
- NEXT: if idx==DEPTH-1 -> DONE (no wrap); else idx+1, then FETCH.
- DONE: busy=0, init_done=1. ERROR: busy=0, init_err=1, err_index=idx.
- Per-entry overhead: 4 cycles (FETCH, ROMWAIT, DECODE, NEXT) plus the write or delay time.
- sccb_done outside WRITE is ignored.
- Reset mid-operation: sccb_req drops asynchronously; sequence aborts; a new start is required.
- The ms counter restarts at 0 on entry to PWRUP and to DELAY.

Decomposition:
- Package sccb_init_pkg: state enum, marker constants, clog2 helper.
- Sub-module ms_tick_timer (params TICK_CYCLES, count width 8):
  - Inputs: load, N. Outputs: expired.
  - Holds a cycle prescaler and an ms down-counter.
  - Used by both PWRUP and DELAY.

Test Plan:
- Nominal run: TICK_CYCLES=10, POWERUP_MS=2, sel=1, table [24'h3103_11, 24'h3008_42, 24'hFFFE_00], master acks 5 cycles after req -> first req 20+3 cycles after start; writes to (3103,11) then (3008,42); addresses 256 and 257 fetched; init_done=1, busy=0; exactly 2 reqs.
- Delay/NOP: entries [24'hFFFF_05, 24'h0000_00, 24'h4300_00] with TICK_CYCLES=10 -> no req for 50 cycles plus overhead; NOP entry gives no req; single write (4300,00).
- Retry: master NACKs the first 2 attempts on (501f,03), MAX_RETRY=3 -> 3 reqs, each separated by exactly 1 low cycle; sequence continues, init_err=0.
- Failure: master always NACKs the entry at idx 7 -> 3 attempts, then init_err=1, err_index=7, busy=0, no further fetch; a new start clears init_err and reruns from idx 0.
- Full table without END_MARK: DEPTH=4, all entries writes -> 4 writes, then DONE; rom_addr never exceeds sel*4+3.
- Reset/start abuse: start pulsed during WRITE -> ignored; rst_n low during WRITE -> sccb_req=0 in the same cycle, all outputs 0; after release, no activity until start.
